biquad_coeff_sequencer: RTL and testbench

- Wishbone-classic master that loads a staged coefficient set into the dual-biquad notch stage of the trigger filter chain (through that stage's 22-bit-address / 32-bit-data Wishbone target), then pulses the biquad filter-state reset.
- Software stages address/data pairs locally, then issues one `apply`. The block plays the writes back in order and clears filter state, so a notch retune is atomic from the datapath's point of view.

---
 rtl/bqseq_pkg.sv | 18 +
 rtl/biquad_coeff_sequencer_if.sv | 25 ++
 rtl/bqseq_stage_ram.sv | 44 ++++
 rtl/biquad_coeff_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_biquad_coeff_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bqseq_pkg.sv
// Shared types and constants for the biquad coefficient sequencer.
package bqseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESET = 3'd4,
    ST_DONE  = 3'd5
  } bqseq_state_e;

  // Wide enough for any sane DATA_W; the top slices off DATA_W/8 bits.
  localparam logic [63:0] WB_SEL_ONES = '1;

  localparam int TMO_W = 16;

endpackage

// File: rtl/biquad_coeff_sequencer_if.sv
// Wishbone-classic bus between the sequencer (master) and the notch-stage target.
interface biquad_coeff_sequencer_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
) ();
  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_o;
  logic [DATA_W/8-1:0] sel;
  logic [DATA_W-1:0] dat_i;
  logic              ack;
  logic              err;

  modport master (
    output cyc, stb, we, adr, dat_o, sel,
    input  dat_i, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_o, sel,
    output dat_i, ack, err
  );
endinterface

// File: rtl/bqseq_stage_ram.sv
// Staging store for address/data pairs: one synchronous write port, one registered read port.
module bqseq_stage_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 54
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data only moves on request so the bus stays stable for a whole transfer.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/biquad_coeff_sequencer.sv
// Plays staged address/data writes to the notch biquad target, then pulses its filter-state reset.
// Optional BQSEQ_READBACK_EN adds a verifying read after every acked write.
//   state | meaning
//   IDLE  | staging writable, waiting for apply
//   FETCH | registered staging read of entry idx
//   WRITE | Wishbone write of entry idx
//   READ  | Wishbone readback of entry idx (readback builds)
//   RESET | reset_bq_o asserted for RESET_CYCLES
//   DONE  | one-cycle done pulse
module biquad_coeff_sequencer
  import bqseq_pkg::*;
#(
  parameter int NUM_ENTRIES  = 32,
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 32,
  parameter int RESET_CYCLES = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_ni,
  input  logic                           stage_we_i,
  input  logic [$clog2(NUM_ENTRIES)-1:0] stage_idx_i,
  input  logic [ADDR_W-1:0]              stage_adr_i,
  input  logic [DATA_W-1:0]              stage_dat_i,
  input  logic [$clog2(NUM_ENTRIES):0]   count_i,
  input  logic                           apply_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [$clog2(NUM_ENTRIES)-1:0] err_idx_o,
  biquad_coeff_sequencer_if.master       wbm,
  output logic                           reset_bq_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_ENTRIES);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_CYCLES - 1);

  bqseq_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;

  logic [CNT_W-1:0]  cnt_clamped;
  logic              last_entry;
  logic              fail;
  logic              go_reset;
  logic              advance;
  logic              in_write;
  logic              in_read;
  logic [ENT_W-1:0]  entry;
  logic [ADDR_W-1:0] entry_adr;
  logic [DATA_W-1:0] entry_dat;

  bqseq_stage_ram #(
    .DEPTH (NUM_ENTRIES),
    .WIDTH (ENT_W)
  ) u_stage_ram (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .we_i    (stage_we_i && (state_q == ST_IDLE)),
    .waddr_i (stage_idx_i),
    .wdata_i ({stage_adr_i, stage_dat_i}),
    .re_i    (state_q == ST_FETCH),
    .raddr_i (idx_q),
    .rdata_o (entry)
  );

  assign entry_adr   = entry[ENT_W-1:DATA_W];
  assign entry_dat   = entry[DATA_W-1:0];
  assign cnt_clamped = (count_i > CNT_MAX) ? CNT_MAX : count_i;
  assign last_entry  = ({1'b0, idx_q} + 1'b1) == cnt_q;

  assign in_write = (state_q == ST_WRITE);
`ifdef BQSEQ_READBACK_EN
  assign in_read  = (state_q == ST_READ);
`else
  assign in_read  = 1'b0;
  logic unused_dat_r;
  assign unused_dat_r = ^wbm.dat_i;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    tmo_d     = tmo_q;
    rst_cnt_d = rst_cnt_q;
    fail      = 1'b0;
    go_reset  = 1'b0;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (apply_i) begin
          cnt_d     = cnt_clamped;
          idx_d     = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
          if (cnt_clamped == '0) begin
            go_reset = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        state_d = ST_WRITE;
        tmo_d   = TMO_LOAD;
      end
      ST_WRITE: begin
        // err wins over a simultaneous ack
        if (wbm.err) begin
          fail = 1'b1;
        end else if (wbm.ack) begin
`ifdef BQSEQ_READBACK_EN
          state_d = ST_READ;
          tmo_d   = TMO_LOAD;
`else
          advance = 1'b1;
`endif
        end else if (tmo_q == '0) begin
          fail = 1'b1;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
`ifdef BQSEQ_READBACK_EN
      ST_READ: begin
        if (wbm.err) begin
          fail = 1'b1;
        end else if (wbm.ack) begin
          if (wbm.dat_i != entry_dat) begin
            fail = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end else if (tmo_q == '0) begin
          fail = 1'b1;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
`endif
      ST_RESET: begin
        if (rst_cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      if (last_entry) begin
        go_reset = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_FETCH;
      end
    end

    // Any failure abandons the rest of the set but still clears filter state.
    if (fail) begin
      err_d    = 1'b1;
      go_reset = 1'b1;
      if (!err_q) begin
        err_idx_d = idx_q;
      end
    end

    if (go_reset) begin
      state_d   = ST_RESET;
      rst_cnt_d = RST_LOAD;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      tmo_q     <= '0;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      tmo_q     <= tmo_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o     = (state_q == ST_DONE);
  assign err_o      = err_q;
  assign err_idx_o  = err_idx_q;
  assign reset_bq_o = (state_q == ST_RESET);

  assign wbm.cyc   = in_write || in_read;
  assign wbm.stb   = in_write || in_read;
  assign wbm.we    = in_write;
  assign wbm.adr   = entry_adr;
  assign wbm.dat_o = entry_dat;
  assign wbm.sel   = (in_write || in_read) ? WB_SEL_ONES[DATA_W/8-1:0] : '0;

endmodule

// File: tb/tb_biquad_coeff_sequencer.sv
// Scoreboard bench for biquad_coeff_sequencer: stimulus pushes expected transfers/completions, a monitor checks them.
module tb_biquad_coeff_sequencer;

  localparam int RESET_CYCLES = 16;

  typedef struct {
    logic [21:0] adr;
    logic [31:0] dat;
    int          term;
    int          len;
  } xfer_t;

  typedef struct {
    int cyc;
    bit err;
    int idx;
  } done_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stage_we = 1'b0;
  logic [4:0]  stage_idx = '0;
  logic [21:0] stage_adr = '0;
  logic [31:0] stage_dat = '0;
  logic [5:0]  count = '0;
  logic        apply = 1'b0;
  logic        busy, done, err, reset_bq;
  logic [4:0]  err_idx;

  logic        ack_en = 1'b1;
  logic        err_en = 1'b0;
  logic [21:0] err_adr = '0;

  int total = 0;
  int bad = 0;
  int cyc_no = 0;
  int done_seen = 0;

  xfer_t xq[$];
  done_t dq[$];

  biquad_coeff_sequencer_if #(.ADDR_W(22), .DATA_W(32)) wb ();

  biquad_coeff_sequencer dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .stage_we_i  (stage_we),
    .stage_idx_i (stage_idx),
    .stage_adr_i (stage_adr),
    .stage_dat_i (stage_dat),
    .count_i     (count),
    .apply_i     (apply),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_idx_o   (err_idx),
    .wbm         (wb),
    .reset_bq_o  (reset_bq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  // Zero-wait target: acks every strobe unless told to error on one address or stay silent.
  assign wb.err   = wb.cyc & wb.stb & err_en & (wb.adr == err_adr);
  assign wb.ack   = wb.cyc & wb.stb & ack_en & ~(err_en & (wb.adr == err_adr));
  assign wb.dat_i = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  int          stb_len = 0;
  int          rbq_len = 0;
  logic [21:0] m_adr;
  logic [31:0] m_dat;
  logic        m_we;
  logic [3:0]  m_sel;

  task automatic close_xfer(input int term);
    xfer_t e;
    if (xq.size() == 0) begin
      chk("xfer_unexpected", 64'(m_adr), 64'hFFFF_FFFF);
    end else begin
      e = xq.pop_front();
      chk("xfer_adr", 64'(m_adr), 64'(e.adr));
      chk("xfer_dat", 64'(m_dat), 64'(e.dat));
      chk("xfer_we", 64'(m_we), 64'd1);
      chk("xfer_sel", 64'(m_sel), 64'hF);
      chk("xfer_term", 64'(term), 64'(e.term));
      chk("xfer_len", 64'(stb_len), 64'(e.len));
    end
  endtask

  always @(negedge clk) begin
    done_t d;
    if (!rst_n) begin
      stb_len = 0;
      rbq_len = 0;
    end else begin
      if (wb.cyc && wb.stb) begin
        stb_len++;
        m_adr = wb.adr;
        m_dat = wb.dat_o;
        m_we  = wb.we;
        m_sel = wb.sel;
        if (wb.ack || wb.err) begin
          close_xfer(wb.err ? 1 : 0);
          stb_len = 0;
        end
      end else if (stb_len != 0) begin
        close_xfer(2);
        stb_len = 0;
      end
      if (reset_bq) rbq_len++;
      if (done) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 64'(cyc_no), 64'hFFFF_FFFF);
        end else begin
          d = dq.pop_front();
          chk("done_cycle", 64'(cyc_no), 64'(d.cyc));
          chk("done_err", 64'(err), 64'(d.err));
          if (d.err) chk("done_err_idx", 64'(err_idx), 64'(d.idx));
          chk("done_busy", 64'(busy), 64'd0);
          chk("reset_bq_width", 64'(rbq_len), 64'(RESET_CYCLES));
        end
        rbq_len = 0;
        done_seen++;
      end
    end
  end

  task automatic push_x(input logic [21:0] a, input logic [31:0] d, input int term, input int len);
    xfer_t e;
    e.adr = a; e.dat = d; e.term = term; e.len = len;
    xq.push_back(e);
  endtask

  task automatic stage(input int idx, input logic [21:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    stage_we = 1'b1; stage_idx = 5'(idx); stage_adr = a; stage_dat = d;
    @(posedge clk); #1;
    stage_we = 1'b0;
  endtask

  // Drives apply for one cycle; cycle 0 is the cycle apply is high.
  task automatic do_apply(input logic [5:0] n, input int lat, input bit e, input int eidx, input bit expect_done);
    done_t d;
    @(posedge clk); #1;
    apply = 1'b1; count = n;
    if (expect_done) begin
      d.cyc = cyc_no + lat; d.err = e; d.idx = eidx;
      dq.push_back(d);
    end
    @(posedge clk); #1;
    apply = 1'b0;
  endtask

  task automatic wait_done(input int target, input int max);
    int n = 0;
    while (done_seen < target && n < max) begin
      @(posedge clk);
      n++;
    end
    chk("done_wait", 64'(done_seen), 64'(target));
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tgt;
    int n;
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cyc", 64'(wb.cyc), 64'd0);
    chk("rst_reset_bq", 64'(reset_bq), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_err", 64'(err), 64'd0);
    chk("idle_err_idx", 64'(err_idx), 64'd0);
    chk("idle_stb", 64'(wb.stb), 64'd0);
    chk("idle_sel", 64'(wb.sel), 64'd0);
    chk("idle_adr", 64'(wb.adr), 64'd0);
    chk("idle_dat", 64'(wb.dat_o), 64'd0);

    // three zero-wait writes
    stage(0, 22'h000010, 32'h11);
    stage(1, 22'h000014, 32'h22);
    stage(2, 22'h000018, 32'h33);
    push_x(22'h000010, 32'h11, 0, 1);
    push_x(22'h000014, 32'h22, 0, 1);
    push_x(22'h000018, 32'h33, 0, 1);
    tgt = done_seen + 1;
    do_apply(6'd3, 23, 1'b0, 0, 1'b1);
    @(negedge clk);
    chk("busy_in_fetch", 64'(busy), 64'd1);
    chk("cyc_low_in_fetch", 64'(wb.cyc), 64'd0);
    @(negedge clk);
    chk("cyc_high_in_write", 64'(wb.cyc), 64'd1);
    wait_done(tgt, 200);

    // empty set: reset pulse only
    tgt = done_seen + 1;
    do_apply(6'd0, 17, 1'b0, 0, 1'b1);
    wait_done(tgt, 200);

    // error on entry 1 skips entry 2
    err_en = 1'b1; err_adr = 22'h000014;
    push_x(22'h000010, 32'h11, 0, 1);
    push_x(22'h000014, 32'h22, 1, 1);
    tgt = done_seen + 1;
    do_apply(6'd3, 21, 1'b1, 1, 1'b1);
    wait_done(tgt, 200);
    err_en = 1'b0;

    // silent target: timeout
    ack_en = 1'b0;
    push_x(22'h000010, 32'h11, 2, 255);
    tgt = done_seen + 1;
    do_apply(6'd1, 273, 1'b1, 0, 1'b1);
    wait_done(tgt, 600);
    ack_en = 1'b1;

    // apply and staging writes while busy are ignored
    stage(0, 22'h000020, 32'hA5);
    stage(1, 22'h000024, 32'h5A);
    push_x(22'h000020, 32'hA5, 0, 1);
    push_x(22'h000024, 32'h5A, 0, 1);
    tgt = done_seen + 1;
    do_apply(6'd2, 21, 1'b0, 0, 1'b1);
    @(posedge clk); #1;
    apply = 1'b1; count = 6'd1;
    stage_we = 1'b1; stage_idx = 5'd1; stage_adr = 22'h3FFFFF; stage_dat = 32'hDEADBEEF;
    @(posedge clk); #1;
    apply = 1'b0; stage_we = 1'b0;
    wait_done(tgt, 200);
    push_x(22'h000020, 32'hA5, 0, 1);
    push_x(22'h000024, 32'h5A, 0, 1);
    tgt = done_seen + 1;
    do_apply(6'd2, 21, 1'b0, 0, 1'b1);
    wait_done(tgt, 200);

    // same-cycle stage write and apply
    push_x(22'h000030, 32'h77, 0, 1);
    tgt = done_seen + 1;
    @(posedge clk); #1;
    stage_we = 1'b1; stage_idx = 5'd0; stage_adr = 22'h000030; stage_dat = 32'h77;
    stage_we = 1'b1;
    begin
      done_t d;
      d.cyc = cyc_no + 19; d.err = 1'b0; d.idx = 0;
      dq.push_back(d);
    end
    apply = 1'b1; count = 6'd1;
    @(posedge clk); #1;
    apply = 1'b0; stage_we = 1'b0;
    wait_done(tgt, 200);

    // count above depth is clamped to all 32 entries
    for (int i = 0; i < 32; i++) begin
      stage(i, 22'(32'h100 + 4 * i), 32'h01010101 * i);
    end
    for (int i = 0; i < 32; i++) begin
      push_x(22'(32'h100 + 4 * i), 32'h01010101 * i, 0, 1);
    end
    tgt = done_seen + 1;
    do_apply(6'd63, 81, 1'b0, 0, 1'b1);
    wait_done(tgt, 400);

    // reset in the middle of a write
    ack_en = 1'b0;
    do_apply(6'd1, 0, 1'b0, 0, 1'b0);
    n = 0;
    while (!wb.cyc && n < 10) begin
      @(posedge clk);
      n++;
    end
    chk("rst_mid_saw_cyc", 64'(wb.cyc), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", 64'(wb.cyc), 64'd0);
    chk("rst_mid_stb", 64'(wb.stb), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_reset_bq", 64'(reset_bq), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    push_x(22'h000100, 32'h00000000, 0, 1);
    push_x(22'h000104, 32'h01010101, 0, 1);
    tgt = done_seen + 1;
    do_apply(6'd2, 21, 1'b0, 0, 1'b1);
    wait_done(tgt, 200);

    chk("xfers_left", 64'(xq.size()), 64'd0);
    chk("dones_left", 64'(dq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
